trace_pkt_buffer: RTL and testbench
===================================

Name: trace_pkt_buffer

Overview:
- Parametrised successor to the fixed 3-lane retire trace packet: buffers per-lane retire trace records from the decode/commit stage in a DEPTH-entry FIFO and drains them to the external trace port.
- NUM_LANES records enter per cycle and up to OUT_LANES leave per cycle, on a valid/ready handshake.
- Supports drop or stall overflow policy, flush, and a saturating drop counter.

Parameters:
- NUM_LANES, 3, retire lanes presented per cycle (1..4).
- OUT_LANES, 1, records offered per cycle on the output (1..NUM_LANES).
- DEPTH, 8, FIFO entries; power of 2, DEPTH >= NUM_LANES.
- STALL_MODE, 0, 0 = drop whole group on overflow; 1 = backpressure through in_ready.
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset, synchronous, active-low
- flush  in  1  discard all buffered records
- in_valid  in  NUM_LANES  per-lane record valid; may be sparse
- in_rec  in  NUM_LANES*103  per-lane {insn[31:0], addr[31:0], exc, ecause[4:0], intr, tval[31:0]}, lane 0 in the LSBs
- in_ready  out  1  group can be accepted this cycle
- out_valid  out  OUT_LANES  thermometer-coded valid, bit 0 = oldest record
- out_rec  out  OUT_LANES*103  oldest records, oldest in slot 0
- out_ready  in  1  consumer takes every valid slot this cycle
- overflow  out  1  sticky: at least one group dropped since reset or flush
- drop_cnt  out  CNT_W  saturating count of dropped records

Behaviour:
- Reset (rst_l sampled low at a clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid = 0, overflow = 0, drop_cnt = 0.
  - in_ready = 1 in both modes.
  - Entry storage is not reset.
- Accounting:
  - push_n = popcount(in_valid).
  - free = DEPTH - count, taken at the start of the cycle; a same-cycle pop does not create space.
- in_ready:
  - STALL_MODE=1: in_ready = (free >= NUM_LANES), conservative and registered-count based.
  - STALL_MODE=0: in_ready = 1.
- Push:
  - Valid lanes are compacted in ascending lane order and written to consecutive entries starting at wr_ptr. wr_ptr advances by push_n, wrapping modulo DEPTH.
  - STALL_MODE=1: the group is accepted only when in_ready = 1. Otherwise nothing is written and the producer must hold its inputs; no drop is counted.
  - STALL_MODE=0: the group is accepted if push_n <= free.
  - STALL_MODE=0 with push_n > free: the entire group is dropped atomically (no partial write), overflow is set, and drop_cnt += push_n, saturating at all-ones.
- Output:
  - out_valid[k] = (count > k) for k < OUT_LANES.
  - out_rec slot k = entry[(rd_ptr + k) mod DEPTH], read combinationally from the storage flops.
  - Pop: when out_ready & out_valid[0], pop_n = popcount(out_valid); rd_ptr advances by pop_n, wrapping.
  - out_ready with out_valid = 0 has no effect.
- Latency: a record pushed at edge N is visible on out_valid/out_rec after edge N, i.e. usable in cycle N+1. No bypass when the FIFO is empty.
- Simultaneous push and pop: count_next = count + push_accepted_n - pop_n. A full FIFO with a same-cycle pop still rejects or drops a group that exceeds the start-of-cycle free.
- Flush:
  - Has priority over push and pop in the same cycle: pointers and count go to 0, the input group is discarded (not counted as a drop), and overflow is cleared.
  - drop_cnt is NOT cleared by flush.
- Boundaries:
  - count never exceeds DEPTH.
  - push_n = 0 is a no-op.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Reset asserted mid-operation wins over flush, push and pop.
- Assertions (verification):
  - out_valid is thermometer-coded.
  - count <= DEPTH.
  - In STALL_MODE=1, no drop_cnt change ever occurs.

Decomposition:
- Shared package (swerv_types): trace_rec_t, a packed 103-bit record struct, plus a localparam for its width. in_rec/out_rec are arrays of trace_rec_t.
- One sub-module, trace_lane_compact: combinational prefix-count compaction of sparse in_valid into dense write slots plus push_n. It is instantiated once.

Test Plan:
- Reset, then in_valid=3'b101 with records A,B, OUT_LANES=1, out_ready=1 -> A on slot 0 in cycle 2, B in cycle 3, out_valid=0 in cycle 4.
- DEPTH=8, STALL_MODE=0, out_ready=0: push 3,3,3 valid lanes -> first two groups stored (count=6), third dropped whole, overflow=1, drop_cnt=3, count stays 6.
- Same fill with STALL_MODE=1 -> in_ready=0 once count=6; held group is accepted only after 1 pop raises free to 3; drop_cnt stays 0.
- OUT_LANES=2, count=1 -> out_valid=2'b01. With out_ready=1, the pop empties the FIFO. Simultaneous push of 2 -> count=2 next cycle.
- Wrap: with wr_ptr=7, push 3 records -> entries 7,0,1 written and read back in order X,Y,Z.
- flush with a pending group and drop_cnt=5 -> count=0, overflow=0, drop_cnt=5. Then drive drop_cnt to saturation (CNT_W=4) -> holds at 15.

Source files
------------

// File: rtl/swerv_types.sv
// Shared retire-trace types: one packed record per retired instruction lane.
package swerv_types;

    localparam int TRACE_REC_W = 103;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic [4:0]  ecause;
        logic        intr;
        logic [31:0] tval;
    } trace_rec_t;

endpackage

// File: rtl/trace_pkt_buffer_if.sv
// Producer/consumer bundle of the trace packet buffer; slave is the buffer side.
interface trace_pkt_buffer_if #(
    parameter int NUM_LANES = 3,
    parameter int OUT_LANES = 1,
    parameter int CNT_W     = 16
);
    logic                                          flush;
    logic [NUM_LANES-1:0]                          in_valid;
    swerv_types::trace_rec_t [NUM_LANES-1:0]       in_rec;
    logic                                          in_ready;
    logic [OUT_LANES-1:0]                          out_valid;
    swerv_types::trace_rec_t [OUT_LANES-1:0]       out_rec;
    logic                                          out_ready;
    logic                                          overflow;
    logic [CNT_W-1:0]                              drop_cnt;

    modport master (
        output flush, in_valid, in_rec, out_ready,
        input  in_ready, out_valid, out_rec, overflow, drop_cnt
    );

    modport slave (
        input  flush, in_valid, in_rec, out_ready,
        output in_ready, out_valid, out_rec, overflow, drop_cnt
    );
endinterface

// File: rtl/trace_lane_compact.sv
// Packs sparse valid lanes into dense write slots: slot j takes the j-th valid lane.
module trace_lane_compact #(
    parameter int NUM_LANES = 3,
    parameter int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    parameter int LCW       = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]          in_valid_i,
    output logic [NUM_LANES-1:0][LW-1:0]  slot_src_o,
    output logic [NUM_LANES-1:0]          slot_vld_o,
    output logic [LCW-1:0]                push_n_o
);
    int c;

    always_comb begin
        c          = 0;
        slot_src_o = '0;
        slot_vld_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (in_valid_i[i]) begin
                slot_src_o[c] = LW'(i);
                slot_vld_o[c] = 1'b1;
                c             = c + 1;
            end
        end
        push_n_o = LCW'(c);
    end
endmodule

// File: rtl/trace_pkt_buffer.sv
// Retire trace FIFO: NUM_LANES sparse records in per cycle, up to OUT_LANES oldest out.
module trace_pkt_buffer
    import swerv_types::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int OUT_LANES  = 1,
    parameter int DEPTH      = 8,
    parameter int STALL_MODE = 0,
    parameter int CNT_W      = 16
) (
    input logic            clk,
    input logic            rst_l,
    trace_pkt_buffer_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int LCW = $clog2(NUM_LANES + 1);
    localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    trace_rec_t                   mem_q [DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d, free, pop_n;
    logic                         overflow_q, overflow_d;
    logic [CNT_W-1:0]             drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]               drop_sum;
    logic [NUM_LANES-1:0][LW-1:0] slot_src;
    logic [NUM_LANES-1:0]         slot_vld;
    logic [LCW-1:0]               push_n;
    logic                         accept, push_go, drop;

    trace_lane_compact #(.NUM_LANES(NUM_LANES)) u_compact (
        .in_valid_i (bus.in_valid),
        .slot_src_o (slot_src),
        .slot_vld_o (slot_vld),
        .push_n_o   (push_n)
    );

    // Space is judged on the start-of-cycle count; a same-cycle pop never helps.
    assign free         = CW'(DEPTH) - count_q;
    assign bus.in_ready = (STALL_MODE != 0) ? (free >= CW'(NUM_LANES)) : 1'b1;
    assign accept       = (STALL_MODE != 0) ? bus.in_ready : (CW'(push_n) <= free);
    assign push_go      = accept && !bus.flush;
    assign drop         = (STALL_MODE == 0) && !accept && !bus.flush;
    assign pop_n        = (bus.out_ready && count_q != '0)
                        ? ((count_q >= CW'(OUT_LANES)) ? CW'(OUT_LANES) : count_q) : '0;
    assign drop_sum     = (CNT_W+1)'(drop_cnt_q) + (CNT_W+1)'(push_n);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_go) wr_ptr_d = wr_ptr_q + PW'(push_n);
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            count_d  = count_q + (push_go ? CW'(push_n) : CW'(0)) - pop_n;
            if (drop) begin
                overflow_d = 1'b1;
                drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately left unreset; pointers alone define what is live.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_LANES; j++) begin
            if (push_go && slot_vld[j]) mem_q[wr_ptr_q + PW'(j)] <= bus.in_rec[slot_src[j]];
        end
    end

    for (genvar k = 0; k < OUT_LANES; k++) begin : g_out
        assign bus.out_valid[k] = count_q > CW'(k);
        assign bus.out_rec[k]   = mem_q[rd_ptr_q + PW'(k)];
    end

    assign bus.overflow = overflow_q;
    assign bus.drop_cnt = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_l) begin
            assert (count_q <= CW'(DEPTH));
            assert (((bus.out_valid + OUT_LANES'(1)) & bus.out_valid) == '0);
            if (STALL_MODE != 0) assert (drop_cnt_d == drop_cnt_q);
        end
    end
endmodule

// File: tb/tb_trace_pkt_buffer.sv
// Drives a drop-mode and a stall-mode buffer with the same stimulus, each checked against a queue model.
module tb_trace_pkt_buffer;
    typedef logic [102:0] rec_t;

    logic             clk = 1'b0;
    logic             rst_l, flush, out_ready;
    logic [2:0]       in_valid;
    logic [2:0][102:0] in_rec;
    int               n_chk = 0, n_err = 0;

    rec_t q0[$], q1[$];
    int   ovf0, ovf1, dc0, dc1;

    always #5 clk = ~clk;

    trace_pkt_buffer_if #(.NUM_LANES(3), .OUT_LANES(1), .CNT_W(4))  if0 ();
    trace_pkt_buffer_if #(.NUM_LANES(3), .OUT_LANES(2), .CNT_W(16)) if1 ();

    assign if0.flush = flush;  assign if0.in_valid = in_valid;
    assign if0.in_rec = in_rec; assign if0.out_ready = out_ready;
    assign if1.flush = flush;  assign if1.in_valid = in_valid;
    assign if1.in_rec = in_rec; assign if1.out_ready = out_ready;

    trace_pkt_buffer #(.NUM_LANES(3), .OUT_LANES(1), .DEPTH(8), .STALL_MODE(0), .CNT_W(4))
        dut0 (.clk(clk), .rst_l(rst_l), .bus(if0.slave));
    trace_pkt_buffer #(.NUM_LANES(3), .OUT_LANES(2), .DEPTH(8), .STALL_MODE(1), .CNT_W(16))
        dut1 (.clk(clk), .rst_l(rst_l), .bus(if1.slave));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rec_t rnd_rec();
        return {$urandom, $urandom, $urandom, 7'($urandom)};
    endfunction

    // Reference: FIFO as a queue; drop mode keeps a group iff it fits in start-of-cycle space,
    // stall mode keeps it iff a whole 3-lane group would fit.
    task automatic model_upd(input int id);
        rec_t q[$];
        int   ovf, dc, ol, cmax, pushn, free, popn;
        bit   acc;
        if (id == 0) begin q = q0; ovf = ovf0; dc = dc0; ol = 1; cmax = 15; end
        else         begin q = q1; ovf = ovf1; dc = dc1; ol = 2; cmax = 65535; end
        if (!rst_l) begin
            q.delete(); ovf = 0; dc = 0;
        end else if (flush) begin
            q.delete(); ovf = 0;
        end else begin
            pushn = $countones(in_valid);
            free  = 8 - q.size();
            acc   = (id == 1) ? (free >= 3) : (pushn <= free);
            popn  = out_ready ? ((q.size() < ol) ? q.size() : ol) : 0;
            if (!acc && id == 0) begin
                ovf = 1;
                dc  = (dc + pushn > cmax) ? cmax : dc + pushn;
            end
            repeat (popn) void'(q.pop_front());
            if (acc) for (int l = 0; l < 3; l++) if (in_valid[l]) q.push_back(in_rec[l]);
        end
        if (id == 0) begin q0 = q; ovf0 = ovf; dc0 = dc; end
        else         begin q1 = q; ovf1 = ovf; dc1 = dc; end
    endtask

    task automatic check_all();
        logic [1:0] ev;
        chk("in_ready0", 128'(if0.in_ready), 128'(1));
        chk("out_valid0", 128'(if0.out_valid), 128'(q0.size() > 0));
        if (q0.size() > 0) chk("out_rec0", 128'(if0.out_rec[0]), 128'(q0[0]));
        chk("overflow0", 128'(if0.overflow), 128'(ovf0));
        chk("drop_cnt0", 128'(if0.drop_cnt), 128'(dc0));
        ev = {q1.size() > 1, q1.size() > 0};
        chk("in_ready1", 128'(if1.in_ready), 128'(8 - q1.size() >= 3));
        chk("out_valid1", 128'(if1.out_valid), 128'(ev));
        if (q1.size() > 0) chk("out_rec1_s0", 128'(if1.out_rec[0]), 128'(q1[0]));
        if (q1.size() > 1) chk("out_rec1_s1", 128'(if1.out_rec[1]), 128'(q1[1]));
        chk("overflow1", 128'(if1.overflow), 128'(ovf1));
        chk("drop_cnt1", 128'(if1.drop_cnt), 128'(dc1));
    endtask

    task automatic cycle();
        model_upd(0);
        model_upd(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic [2:0] v);
        in_valid = v;
        for (int l = 0; l < 3; l++) in_rec[l] = rnd_rec();
    endtask

    initial begin
        rec_t a, b;
        q0.delete(); q1.delete();
        ovf0 = 0; ovf1 = 0; dc0 = 0; dc1 = 0;
        rst_l = 1'b0; flush = 1'b0; out_ready = 1'b0; drive(3'b000);
        repeat (2) cycle();
        chk("rst_in_ready0", 128'(if0.in_ready), 128'(1));
        chk("rst_in_ready1", 128'(if1.in_ready), 128'(1));
        chk("rst_out_valid1", 128'(if1.out_valid), 128'(0));
        chk("rst_drop_cnt0", 128'(if0.drop_cnt), 128'(0));
        rst_l = 1'b1;

        // Sparse lanes 0 and 2 land in consecutive entries, one per cycle on the 1-wide port.
        drive(3'b101); a = in_rec[0]; b = in_rec[2]; out_ready = 1'b1;
        cycle();
        chk("sparse_first", 128'(if0.out_rec[0]), 128'(a));
        drive(3'b000);
        cycle();
        chk("sparse_second", 128'(if0.out_rec[0]), 128'(b));
        cycle();
        chk("sparse_empty", 128'(if0.out_valid), 128'(0));

        // Overflow: third group of 3 dropped in drop mode, held off in stall mode.
        out_ready = 1'b0;
        drive(3'b111); cycle();
        drive(3'b111); cycle();
        chk("stall_in_ready_full", 128'(if1.in_ready), 128'(0));
        drive(3'b111); cycle();
        chk("drop_overflow", 128'(if0.overflow), 128'(1));
        chk("drop_cnt_3", 128'(if0.drop_cnt), 128'(3));
        chk("stall_no_drop", 128'(if1.drop_cnt), 128'(0));
        out_ready = 1'b1; cycle();
        out_ready = 1'b0; cycle();
        chk("stall_accept_after_pop", 128'(if1.out_valid), 128'(2'b11));

        // Flush discards the pending group but keeps the drop count.
        flush = 1'b1; cycle();
        flush = 1'b0; drive(3'b000);
        chk("flush_overflow", 128'(if0.overflow), 128'(0));
        chk("flush_keeps_drops", 128'(if0.drop_cnt), 128'(6));
        chk("flush_empty", 128'(if1.out_valid), 128'(0));

        repeat (8) begin drive(3'b111); cycle(); end
        chk("drop_cnt_saturate", 128'(if0.drop_cnt), 128'(15));
        drive(3'b000); flush = 1'b1; cycle(); flush = 1'b0;

        // Random traffic: fill-heavy, then drain-heavy, with rare flush and reset.
        for (int n = 0; n < 600; n++) begin
            drive(3'($urandom_range(0, 7)));
            out_ready = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst_l     = ($urandom_range(0, 150) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
